// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - MSB-first parallel-to-serial front end for seqdetector
// Optional even-parity bit per word when SER_PARITY_EN is defined.
module seq_serializer #(
   parameter int W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [W-1:0]             din,
   input  logic                     load,
   output logic                     ready,
   output logic                     X,
   output logic                     bit_valid,
   output logic                     last,
   output logic [1:0]               state,
   output logic [$clog2(W+1)-1:0]   cnt
);

   localparam int CW = $clog2(W+1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   state_t       st;
   // The MSB goes straight to X on load, so only the remaining W-1 bits are held.
   logic [W-2:0] sreg;
`ifdef SER_PARITY_EN
   logic         par;
`endif

   assign state = st;

   always_ff @(posedge clk) begin
      if (!reset) begin
         st        <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         X         <= 1'b0;
         bit_valid <= 1'b0;
         last      <= 1'b0;
         ready     <= 1'b1;
`ifdef SER_PARITY_EN
         par       <= 1'b0;
`endif
      end else if (load && ready) begin
         st        <= SHIFT;
         sreg      <= din[W-2:0];
         cnt       <= CW'(W);
         X         <= din[W-1];
         bit_valid <= 1'b1;
         last      <= 1'b0;
         ready     <= 1'b0;
`ifdef SER_PARITY_EN
         par       <= ^din;
`endif
      end else begin
         case (st)
            SHIFT: begin
               sreg <= sreg << 1;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
`ifdef SER_PARITY_EN
                  st        <= PAR;
                  X         <= par;
                  bit_valid <= 1'b1;
                  last      <= 1'b1;
                  ready     <= 1'b1;
`else
                  st        <= IDLE;
                  X         <= 1'b0;
                  bit_valid <= 1'b0;
                  last      <= 1'b0;
                  ready     <= 1'b1;
`endif
               end else begin
                  X         <= sreg[W-2];
                  bit_valid <= 1'b1;
`ifdef SER_PARITY_EN
                  last      <= 1'b0;
                  ready     <= 1'b0;
`else
                  last      <= (cnt == CW'(2));
                  ready     <= (cnt == CW'(2));
`endif
               end
            end
            default: begin
               st        <= IDLE;
               sreg      <= '0;
               cnt       <= '0;
               X         <= 1'b0;
               bit_valid <= 1'b0;
               last      <= 1'b0;
               ready     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - table, directed and random checks of seq_serializer
module tb_seq_serializer;

   localparam int W  = 8;
   localparam int CW = $clog2(W+1);
   localparam int OW = 6 + CW;
`ifdef SER_PARITY_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          load;
   logic [W-1:0]  din;
   logic          ready;
   logic          X;
   logic          bit_valid;
   logic          last;
   logic [1:0]    state;
   logic [CW-1:0] cnt;

   seq_serializer #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .load      (load),
      .ready     (ready),
      .X         (X),
      .bit_valid (bit_valid),
      .last      (last),
      .state     (state),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference: queue of bits still to be emitted for the word in flight.
   typedef struct packed {
      logic x;
      logic lst;
      logic par;
   } ent_t;
   ent_t q[$];

   typedef struct {
      logic          r;
      logic          l;
      logic [W-1:0]  d;
      logic [OW-1:0] e;
   } vec_t;
   vec_t vt[12];

   function automatic logic [OW-1:0] obs();
      return {X, bit_valid, last, ready, state, cnt};
   endfunction

   function automatic logic [OW-1:0] model_obs();
      int nd;
      nd = 0;
      if (q.size() == 0) return {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, CW'(0)};
      foreach (q[i]) if (!q[i].par) nd++;
      return {q[0].x, 1'b1, q[0].lst, (q.size() <= 1) ? 1'b1 : 1'b0,
              q[0].par ? 2'd2 : 2'd1, CW'(nd)};
   endfunction

   task automatic model_edge(input logic r, input logic l, input logic [W-1:0] d);
      logic acc;
      ent_t e;
      if (!r) begin
         q.delete();
      end else begin
         acc = l && (q.size() <= 1);
         if (q.size() > 0) void'(q.pop_front());
         if (acc) begin
            for (int i = W-1; i >= 0; i--) begin
               e.x = d[i]; e.lst = (i == 0) && !PE; e.par = 1'b0;
               q.push_back(e);
            end
            if (PE) begin
               e.x = ^d; e.lst = 1'b1; e.par = 1'b1;
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [OW-1:0] a, input logic [OW-1:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %b required %b", nm, a, e);
      end
   endtask

   task automatic chk_int(input string nm, input int a, input int e);
      vectors++;
      if (a != e) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", nm, a, e);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [W-1:0] d);
      reset = r;
      load  = l;
      din   = d;
      @(posedge clk);
      model_edge(r, l, d);
      #1;
      chk("model", obs(), model_obs());
   endtask

   function automatic vec_t mk(input logic r, input logic l, input logic [W-1:0] d,
                               input logic x, input logic bv, input logic ls,
                               input logic rd, input logic [1:0] st, input int c);
      vec_t v;
      v.r = r; v.l = l; v.d = d;
      v.e = {x, bv, ls, rd, st, CW'(c)};
      return v;
   endfunction

   initial begin
      logic bq[$];
      logic eb[$];
      logic [W-1:0] word;
      int loads;
      int rdy_low;

      reset = 1'b0;
      load  = 1'b0;
      din   = '0;

      // Reset with load held high, then a single 8'hA5 word.
      vt[0]  = mk(0, 1, 8'hFF, 0, 0, 0, 1, 0, 0);
      vt[1]  = mk(0, 1, 8'hFF, 0, 0, 0, 1, 0, 0);
      vt[2]  = mk(1, 1, 8'hA5, 1, 1, 0, 0, 1, 8);
      vt[3]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 7);
      vt[4]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 1, 6);
      vt[5]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 5);
      vt[6]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 4);
      vt[7]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 1, 3);
      vt[8]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 2);
      vt[9]  = mk(1, 0, 8'h00, 1, 1, !PE, !PE, 1, 1);
      vt[10] = PE ? mk(1, 0, 8'h00, 0, 1, 1, 1, 2, 0) : mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
      vt[11] = mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 12; i++) begin
         step(vt[i].r, vt[i].l, vt[i].d);
         chk($sformatf("vec%0d", i), obs(), vt[i].e);
      end

      // Back-to-back: FF then 00 loaded during the last cycle of the first word.
      loads = 1;
      step(1, 1, 8'hFF);
      for (int i = 0; i < 40 && bit_valid; i++) begin
         bq.push_back(X);
         if (last && loads == 1) begin
            loads = 2;
            step(1, 1, 8'h00);
         end else begin
            step(1, 0, 8'h00);
         end
      end
      for (int i = 0; i < W; i++) eb.push_back(1'b1);
      if (PE) eb.push_back(1'b0);
      for (int i = 0; i < W; i++) eb.push_back(1'b0);
      if (PE) eb.push_back(1'b0);
      chk_int("b2b_len", bq.size(), eb.size());
      for (int i = 0; i < eb.size() && i < bq.size(); i++)
         chk_int($sformatf("b2b_bit%0d", i), int'(bq[i]), int'(eb[i]));

      // Load pulse while busy must not disturb the word in flight.
      step(1, 0, 8'h00);
      step(1, 1, 8'hF0);
      word    = '0;
      rdy_low = 0;
      for (int j = 1; j <= 8 + int'(PE); j++) begin
         if (j > 1) step(1, j == 4, 8'h0F);
         if (j <= 8) word = {word[W-2:0], X};
         if (!ready) rdy_low++;
      end
      chk_int("busy_word", int'(word), 32'hF0);
      chk_int("busy_ready_low", rdy_low, 7 + int'(PE));
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);

      // Reset in the middle of a word.
      step(1, 1, 8'hAA);
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      step(0, 0, 8'h00);
      chk_int("midreset", int'({X, bit_valid, state, ready}), int'(5'b00001));
      step(1, 0, 8'h00);

`ifdef SER_PARITY_EN
      step(1, 1, 8'h07);
      for (int i = 0; i < 7; i++) step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      chk_int("par07", int'({X, last, state}), int'(4'b1110));
      step(1, 0, 8'h00);
`endif

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)), W'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
